bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and sequencer for the processor's shared 16-bit data bus. Up to N requesters (register file, ALU result, memory, I/O) ask for the bus. The arbiter grants exactly one driver at a time and enforces a one-cycle turnaround between owners so no two tri-state drivers overlap. It also bounds each ownership with a hold timeout so one requester cannot starve the rest. It sits beside the control unit and its one-hot grant gates the bus drive enables.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (1..255)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester bus request, level-sensitive
- done  input  N  per-requester release pulse; only the current owner's bit is honoured
- grant  output  N  one-hot drive enable, registered; all-zero when no owner
- grant_idx  output  $clog2(N)  binary index of current owner; holds last owner when grant is zero
- bus_busy  output  1  high whenever grant is nonzero
- timeout  output  1  one-cycle pulse when an ownership is revoked by MAX_HOLD

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner drives the bus.
  - TURN: one dead cycle with grant all-zero.
- Reset values: state IDLE, grant 0, grant_idx 0, bus_busy 0, timeout 0, hold counter 0, priority pointer N-1. With this pointer, requester 0 has highest priority first.
- Arbitration:
  - Search starts at pointer+1 mod N and takes the first set req bit.
  - On grant, pointer becomes the winner's index.
- IDLE → GRANT when any req bit is set. The winner is loaded into grant and grant_idx, and the hold counter is set to 1.
- GRANT:
  - The counter increments each cycle.
  - Release occurs when any of these holds: done[owner]=1, req[owner]=0, or counter==MAX_HOLD with req[owner] still 1 (this case also pulses timeout).
  - On release, go to TURN and clear grant.
- TURN:
  - grant stays 0 for exactly one cycle.
  - Then arbitrate again: → GRANT if any req is set, else → IDLE.
  - The previous owner competes normally but has lowest priority, because of the pointer.
- done bits of non-owners and done in IDLE/TURN are ignored.
- If the owner asserts done and hits MAX_HOLD in the same cycle, done wins and timeout stays 0.
- Requests that arrive or drop during TURN are sampled only at the end of TURN.
- rst mid-grant: grant drops to 0 on the next edge; the pointer returns to N-1.

## Timing
- Latency from req to grant: 1 cycle from IDLE. req is sampled at edge k and grant is visible after edge k, valid for the cycle following k.
- Minimum gap between two owners: exactly 1 cycle with grant=0.
- Maximum ownership: MAX_HOLD cycles. The timeout pulse coincides with the first TURN cycle.
- All outputs are registered; there are no combinational paths from req or done to grant.
- Worst-case wait for a continuously requesting master: (N-1)·(MAX_HOLD+1) cycles.

## Structure
- Shared package `bus_pkg`: state encoding (IDLE=2'd0, GRANT=2'd1, TURN=2'd2), default N and MAX_HOLD, and the requester index constants (REQ_REGFILE=0, REQ_ALU=1, REQ_MEM=2, REQ_IO=3).
- One sub-module, `rr_pick`: a combinational rotating priority encoder. Inputs are req and pointer; outputs are a found flag and the winner index.
- The FSM, hold counter and pointer live in `bus_arbiter`.

## Test plan
- Reset/idle: hold rst=1 for 2 cycles with req=4'b1111, then release rst. Required: grant=0 during reset; the first grant after reset is 4'b0001 with grant_idx=0.
- Single requester: req=4'b0100 pulsed high for 3 cycles, then low. Required: grant=4'b0100 one cycle after req; grant drops the cycle after req falls; bus_busy tracks grant.
- Round-robin: req=4'b1111 held and each owner pulses done after 2 cycles. Required: grant order 0001, 0010, 0100, 1000, 0001, with exactly one zero-grant cycle between each.
- Timeout: MAX_HOLD=8 and req=4'b0011 held, never done. Required: owner 0 keeps the grant for 8 cycles, timeout pulses once, one dead cycle follows, then grant=4'b0010.
- Simultaneous events:
  - done[owner] together with counter==MAX_HOLD → timeout=0.
  - done from a non-owner → ignored; the grant stays unchanged.
- Reset mid-grant: assert rst while grant=4'b1000. Required: grant=0 the next cycle, and after release with req=4'b1001 the grant goes to index 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus arbiter: state encoding, default sizing and
// the fixed requester slots on the processor's shared bus.
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StTurn  = 2'd2
  } state_e;

  localparam int unsigned NDefault       = 4;
  localparam int unsigned MaxHoldDefault = 8;

  localparam int unsigned REQ_REGFILE = 0;
  localparam int unsigned REQ_ALU     = 1;
  localparam int unsigned REQ_MEM     = 2;
  localparam int unsigned REQ_IO      = 3;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set request at or after ptr_i+1 (mod N).
module rr_pick import bus_pkg::*; #(
  parameter int unsigned N = NDefault
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N);

  // Walk offsets from farthest to nearest so the nearest set request is assigned last.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    for (int off = N; off >= 1; off--) begin
      int cand;
      cand = (int'(ptr_i) + off) % int'(N);
      if (req_i[cand]) begin
        idx_o = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared 16-bit data bus, with a one-cycle
// turnaround between owners and a hold timeout bounding each ownership.
module bus_arbiter import bus_pkg::*; #(
  parameter int unsigned N        = NDefault,
  parameter int unsigned MAX_HOLD = MaxHoldDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         done_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grant_idx_o,
  output logic                 bus_busy_o,
  output logic                 timeout_o
);

  localparam int unsigned IdxW    = $clog2(N);
  localparam logic [7:0]  HoldMax = 8'(MAX_HOLD);

  state_e          state_q;
  logic [N-1:0]    grant_q;
  logic [IdxW-1:0] idx_q;
  logic [IdxW-1:0] ptr_q;
  logic [7:0]      hold_q;
  logic            busy_q;
  logic            timeout_q;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [N-1:0]    pick_onehot;
  logic            owner_req;
  logic            owner_done;
  logic            hold_hit;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Decode the winner and look up the current owner's request/release bits.
  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
    owner_req             = req_i[idx_q];
    owner_done            = done_i[idx_q];
    hold_hit              = (hold_q == HoldMax);
  end

  // Arbiter FSM with hold counter, priority pointer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= IdxW'(N - 1);
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle, StTurn: begin
          // TURN ends here too: requests are only sampled on its closing edge.
          if (pick_found) begin
            state_q <= StGrant;
            grant_q <= pick_onehot;
            idx_q   <= pick_idx;
            ptr_q   <= pick_idx;
            hold_q  <= 8'd1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        StGrant: begin
          if (owner_done || !owner_req || hold_hit) begin
            state_q   <= StTurn;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            // An explicit release takes precedence over the timeout.
            timeout_q <= hold_hit && owner_req && !owner_done;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign bus_busy_o  = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N=4, MAX_HOLD=8).
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       bus_busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .done_i      (done),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .bus_busy_o  (bus_busy),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected grant/idx/busy/timeout.
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic b, input logic t);
    chk({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
    chk({tag, ".idx"}, {6'b0, grant_idx}, {6'b0, idx});
    chk({tag, ".busy"}, {7'b0, bus_busy}, {7'b0, b});
    chk({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
  endtask

  initial begin
    logic [3:0] rr_grant [4];
    logic [1:0] rr_idx   [4];
    rr_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_idx   = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with all requests pending.
    rst  = 1'b1;
    req  = 4'b1111;
    done = 4'b0000;
    tick();
    chk_all("rst1", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("rst2", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Round robin: each owner holds two cycles, then pulses done.
    tick();
    chk("rr0_hold", {4'b0, grant}, 8'h01);
    done = 4'b0001;
    tick();
    chk_all("rr0_turn", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all($sformatf("rr%0d_grant", k + 1), rr_grant[k], rr_idx[k], 1'b1, 1'b0);
      tick();
      chk($sformatf("rr%0d_hold", k + 1), {4'b0, grant}, {4'b0, rr_grant[k]});
      done = rr_grant[k];
      tick();
      chk($sformatf("rr%0d_turn", k + 1), {4'b0, grant}, 8'h00);
      done = 4'b0000;
    end
    // Leave the last turn with nobody requesting.
    req = 4'b0000;
    tick();
    chk_all("rr_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester pulsed for three cycles after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_all("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100;
    tick();
    chk_all("single_g1", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk_all("single_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    chk_all("single_g3", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    chk_all("single_drop", 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    chk_all("single_idle_idx", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Timeout: pointer=2, so requester 0 wins and holds for MAX_HOLD cycles.
    req = 4'b0011;
    tick();
    chk_all("to_g1", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk_all($sformatf("to_g%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_all("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_all("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Non-owner done is ignored.
    done = 4'b0001;
    tick();
    chk_all("nonowner_done", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 4'b0000;
    // Run owner 1 up to hold count 8, then done on the same cycle as the limit.
    for (int c = 3; c <= 8; c++) begin
      tick();
      chk($sformatf("dh_g%0d", c), {4'b0, grant}, 8'h02);
    end
    done = 4'b0010;
    tick();
    chk_all("done_beats_timeout", 4'b0000, 2'd1, 1'b0, 1'b0);
    done = 4'b0000;
    tick();
    chk_all("dh_next", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Hand the bus to requester 3, then reset mid-grant.
    req = 4'b1000;
    tick();
    chk("m_release", {4'b0, grant}, 8'h00);
    tick();
    chk_all("m_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    req = 4'b1001;
    tick();
    chk_all("m_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("m_after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
